// File: rtl/atm_keypad_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, key classes,
// FSM state encoding, the registered output bundle and the decimal-shift helper.
package atm_keypad_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    KIND_DIGIT,
    KIND_ENTER,
    KIND_CLEAR,
    KIND_CANCEL,
    KIND_INVALID
  } key_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIN,
    ST_AMOUNT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [3:0]  digito;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic        modo_monto;
    logic        entry_error;
  } out_t;

  function automatic key_kind_e classify_key(input logic [3:0] code);
    key_kind_e kind;
    case (code)
      KEY_ENTER:  kind = KIND_ENTER;
      KEY_CLEAR:  kind = KIND_CLEAR;
      KEY_CANCEL: kind = KIND_CANCEL;
      default:    kind = (code <= 4'h9) ? KIND_DIGIT : KIND_INVALID;
    endcase
    return kind;
  endfunction

  // acc*10 + d using shifts only; the digit-count limit keeps it inside 32 bits.
  function automatic logic [31:0] mul10_add(input logic [31:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {28'd0, d};
  endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Signal bundle between the keypad/controller side and the keypad front end.
interface atm_keypad_frontend_if;
  logic        tarjeta_recibida;
  logic        pin_incorrecto;
  logic        key_down;
  logic [3:0]  key_code;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        modo_monto;
  logic        entry_error;

  modport master (
    output tarjeta_recibida, pin_incorrecto, key_down, key_code,
    input  digito, digito_stb, monto, monto_stb, modo_monto, entry_error
  );

  modport slave (
    input  tarjeta_recibida, pin_incorrecto, key_down, key_code,
    output digito, digito_stb, monto, monto_stb, modo_monto, entry_error
  );
endinterface

// File: rtl/atm_keypad_frontend_debouncer.sv
// Two-flop synchroniser and debounce counter for the raw key line; emits one
// key_event per accepted press together with the code captured at that moment.
module keypad_debouncer #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_val
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      key_event <= 1'b0;
      key_val   <= 4'h0;
    end else begin
      sync1     <= key_down;
      sync2     <= sync1;
      key_event <= 1'b0;
      // The accepted level flips only after DEBOUNCE_CYC consecutive differing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= sync2;
        if (sync2) begin
          key_event <= 1'b1;
          key_val   <= key_code;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad front end: sequences PIN digits then a decimal amount per card,
// driving the controller's digit strobe and binary amount strobe.
module atm_keypad_frontend
  import atm_keypad_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_AMT_DIGITS = 9,
  parameter int DEBOUNCE_CYC   = 4
) (
  input logic                  clk,
  input logic                  rst,
  atm_keypad_frontend_if.slave bus
);

  localparam int PC_W = $clog2(PIN_DIGITS + 1);
  localparam int AC_W = $clog2(MAX_AMT_DIGITS + 1);

  logic            key_event;
  logic [3:0]      key_val;
  key_kind_e       kind;

  state_e          state, state_n;
  logic [PC_W-1:0] pin_cnt, pin_cnt_n;
  logic [AC_W-1:0] amt_cnt, amt_cnt_n;
  logic [31:0]     acc, acc_n;
  out_t            out_q, out_n;

  keypad_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .key_down (bus.key_down),
    .key_code (bus.key_code),
    .key_event(key_event),
    .key_val  (key_val)
  );

  assign kind = classify_key(key_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pin_cnt <= '0;
      amt_cnt <= '0;
      acc     <= '0;
      out_q   <= '0;
    end else begin
      state   <= state_n;
      pin_cnt <= pin_cnt_n;
      amt_cnt <= amt_cnt_n;
      acc     <= acc_n;
      out_q   <= out_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n           = state;
    pin_cnt_n         = pin_cnt;
    amt_cnt_n         = amt_cnt;
    acc_n             = acc;
    out_n             = out_q;
    out_n.digito_stb  = 1'b0;
    out_n.monto_stb   = 1'b0;
    out_n.entry_error = 1'b0;

    // Card removal outranks everything, then a PIN rejection, then the key itself.
    if (!bus.tarjeta_recibida) begin
      state_n   = ST_IDLE;
      pin_cnt_n = '0;
      amt_cnt_n = '0;
      acc_n     = '0;
    end else if (state == ST_IDLE) begin
      state_n   = ST_PIN;
      pin_cnt_n = '0;
    end else if (bus.pin_incorrecto) begin
      state_n   = ST_PIN;
      pin_cnt_n = '0;
      amt_cnt_n = '0;
      acc_n     = '0;
    end else if (key_event) begin
      case (state)
        ST_PIN: begin
          case (kind)
            KIND_DIGIT: begin
              out_n.digito     = key_val;
              out_n.digito_stb = 1'b1;
              if (pin_cnt == PC_W'(PIN_DIGITS - 1)) begin
                state_n   = ST_AMOUNT;
                pin_cnt_n = '0;
                amt_cnt_n = '0;
                acc_n     = '0;
              end else begin
                pin_cnt_n = pin_cnt + 1'b1;
              end
            end
            KIND_CANCEL: pin_cnt_n = '0;
            default:     out_n.entry_error = 1'b1;
          endcase
        end
        ST_AMOUNT: begin
          case (kind)
            KIND_DIGIT: begin
              if (amt_cnt < AC_W'(MAX_AMT_DIGITS)) begin
                acc_n     = mul10_add(acc, key_val);
                amt_cnt_n = amt_cnt + 1'b1;
              end else begin
                out_n.entry_error = 1'b1;
              end
            end
            KIND_CLEAR: begin
              acc_n     = '0;
              amt_cnt_n = '0;
            end
            KIND_ENTER: begin
              if (amt_cnt != '0) begin
                out_n.monto     = acc;
                out_n.monto_stb = 1'b1;
                state_n         = ST_DONE;
              end else begin
                out_n.entry_error = 1'b1;
              end
            end
            KIND_CANCEL: begin
              state_n   = ST_PIN;
              pin_cnt_n = '0;
              amt_cnt_n = '0;
              acc_n     = '0;
            end
            default: out_n.entry_error = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    out_n.modo_monto = (state_n == ST_AMOUNT);
  end

  assign bus.digito      = out_q.digito;
  assign bus.digito_stb  = out_q.digito_stb;
  assign bus.monto       = out_q.monto;
  assign bus.monto_stb   = out_q.monto_stb;
  assign bus.modo_monto  = out_q.modo_monto;
  assign bus.entry_error = out_q.entry_error;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Self-checking bench for atm_keypad_frontend: directed scenarios followed by
// random key sequences, checked against a per-keypress behavioural model.
module tb_atm_keypad_frontend;

  localparam int D     = 4;
  localparam int PIN_N = 4;
  localparam int MAX_N = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_keypad_frontend_if bus ();

  atm_keypad_frontend #(
    .PIN_DIGITS    (PIN_N),
    .MAX_AMT_DIGITS(MAX_N),
    .DEBOUNCE_CYC  (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: works per accepted keypress, amount kept as a list of decimal digits.
  typedef enum {M_IDLE, M_PIN, M_AMT, M_DONE} mmode_e;
  mmode_e      m_mode;
  int          m_pin;
  int          amt_q[$];
  logic [3:0]  m_digito;
  logic [31:0] m_monto;
  bit          e_dstb, e_mstb, e_err;

  function automatic logic [31:0] decimal_value();
    longint v = 0;
    foreach (amt_q[i]) v = v * 10 + amt_q[i];
    return v[31:0];
  endfunction

  task automatic model_key(input logic [3:0] k);
    e_dstb = 0; e_mstb = 0; e_err = 0;
    case (m_mode)
      M_PIN: begin
        if (k < 4'd10) begin
          e_dstb = 1; m_digito = k; m_pin++;
          if (m_pin == PIN_N) begin m_mode = M_AMT; m_pin = 0; amt_q.delete(); end
        end else if (k == 4'hC) m_pin = 0;
        else e_err = 1;
      end
      M_AMT: begin
        if (k < 4'd10) begin
          if (amt_q.size() < MAX_N) amt_q.push_back(int'(k));
          else e_err = 1;
        end else if (k == 4'hB) amt_q.delete();
        else if (k == 4'hA) begin
          if (amt_q.size() == 0) e_err = 1;
          else begin m_monto = decimal_value(); e_mstb = 1; m_mode = M_DONE; end
        end else if (k == 4'hC) begin m_mode = M_PIN; m_pin = 0; amt_q.delete(); end
        else e_err = 1;
      end
      default: ;
    endcase
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dstb"}, 32'(bus.digito_stb), 32'd0);
    check({tag, "_mstb"}, 32'(bus.monto_stb), 32'd0);
    check({tag, "_err"},  32'(bus.entry_error), 32'd0);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_digito"}, 32'(bus.digito), 32'(m_digito));
    check({tag, "_monto"},  bus.monto, m_monto);
    check({tag, "_modo"},   32'(bus.modo_monto), 32'(m_mode == M_AMT));
  endtask

  // kill: 0 none, 1 drop the card while key_event is high, 2 pulse pin_incorrecto then.
  task automatic press(input logic [3:0] k, input int hold, input int kill);
    bit ev;
    ev = (hold >= D);
    @(negedge clk);
    bus.key_code = k;
    bus.key_down = 1'b1;
    for (int e = 1; e <= hold + D + 6; e++) begin
      @(posedge clk); #1;
      if (ev && e == D + 3) begin
        model_key(k);
        check("key_dstb", 32'(bus.digito_stb), 32'(e_dstb));
        check("key_mstb", 32'(bus.monto_stb), 32'(e_mstb));
        check("key_err",  32'(bus.entry_error), 32'(e_err));
        check_held("key");
      end else begin
        check_quiet("between");
        if (e == D + 3) check_held("nokey");
      end
      if (e == hold) bus.key_down = 1'b0;
      if (ev && e == D + 2 && kill == 1) begin
        bus.tarjeta_recibida = 1'b0;
        m_mode = M_IDLE; m_pin = 0; amt_q.delete();
        ev = 0;
      end
      if (ev && e == D + 2 && kill == 2) begin
        bus.pin_incorrecto = 1'b1;
        if (m_mode != M_IDLE) begin m_mode = M_PIN; m_pin = 0; amt_q.delete(); end
        ev = 0;
      end
      if (e == D + 3) bus.pin_incorrecto = 1'b0;
    end
  endtask

  task automatic pulse_pin_incorrecto();
    @(posedge clk); #1;
    bus.pin_incorrecto = 1'b1;
    @(posedge clk); #1;
    bus.pin_incorrecto = 1'b0;
    if (m_mode != M_IDLE) begin m_mode = M_PIN; m_pin = 0; amt_q.delete(); end
    check_quiet("pinc");
    check_held("pinc");
  endtask

  task automatic card_cycle();
    @(posedge clk); #1;
    bus.tarjeta_recibida = 1'b0;
    @(posedge clk); #1;
    m_mode = M_IDLE; m_pin = 0; amt_q.delete();
    check_held("card_out");
    bus.tarjeta_recibida = 1'b1;
    @(posedge clk); #1;
    m_mode = M_PIN;
    check_held("card_in");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digito"}, 32'(bus.digito), 32'd0);
    check({tag, "_monto"},  bus.monto, 32'd0);
    check({tag, "_modo"},   32'(bus.modo_monto), 32'd0);
    check_quiet(tag);
  endtask

  task automatic reset_mid();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    m_mode = M_IDLE; m_pin = 0; amt_q.delete(); m_digito = 4'h0; m_monto = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    if (bus.tarjeta_recibida) m_mode = M_PIN;
    check_held("rst_rel");
  endtask

  task automatic enter_pin();
    for (int i = 1; i <= PIN_N; i++) press(4'(i), 10, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.tarjeta_recibida = 1'b0;
    bus.pin_incorrecto   = 1'b0;
    bus.key_down         = 1'b0;
    bus.key_code         = 4'h0;
    m_mode = M_IDLE; m_pin = 0; m_digito = 4'h0; m_monto = 32'd0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Keys in IDLE are ignored without error.
    press(4'h5, 10, 0);
    @(posedge clk); #1;
    bus.tarjeta_recibida = 1'b1;
    @(posedge clk); #1;
    m_mode = M_PIN;

    // 1: PIN 1,2,3,4
    enter_pin();
    check("modo_after_pin", 32'(bus.modo_monto), 32'd1);

    // 2: amount 500
    press(4'h5, 10, 0); press(4'h0, 10, 0); press(4'h0, 10, 0); press(4'hA, 10, 0);
    check("monto_500", bus.monto, 32'h1F4);

    // 3: 7, CLEAR, 2, 5, ENTER -> 25; then ENTER with no digits
    card_cycle(); enter_pin();
    press(4'h7, 10, 0); press(4'hB, 10, 0); press(4'h2, 10, 0); press(4'h5, 10, 0);
    press(4'hA, 10, 0);
    check("monto_25", bus.monto, 32'd25);
    card_cycle(); enter_pin();
    press(4'hA, 10, 0);

    // 4: ten 9s then ENTER
    for (int i = 0; i < 10; i++) press(4'h9, 8, 0);
    press(4'hA, 8, 0);
    check("monto_max", bus.monto, 32'd999_999_999);

    // 5: glitch then long press
    card_cycle();
    press(4'h3, 2, 0);
    press(4'h3, 50, 0);

    // 6: pin_incorrecto mid-amount, card drop during key_event, reset mid-PIN
    card_cycle(); enter_pin();
    press(4'h1, 8, 0); press(4'h2, 8, 0);
    pulse_pin_incorrecto();
    check("modo_after_pinc", 32'(bus.modo_monto), 32'd0);
    press(4'h6, 10, 1);
    @(posedge clk); #1;
    bus.tarjeta_recibida = 1'b1;
    @(posedge clk); #1;
    m_mode = M_PIN;
    press(4'h7, 8, 0); press(4'h8, 8, 0);
    reset_mid();

    // Random phase
    for (int it = 0; it < 200; it++) begin
      int r;
      logic [3:0] k;
      int hold;
      r = $urandom_range(0, 99);
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      hold = (r < 20) ? $urandom_range(1, 3) : $urandom_range(5, 14);
      if (r < 5) card_cycle();
      else if (r < 10) pulse_pin_incorrecto();
      else if (r < 13) reset_mid();
      else press(k, hold, (r >= 96) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
